// File: rtl/ysyx_23060191_ifu_pkg.sv
// ysyx_23060191_ifu_pkg: shared widths, reset PC, PC step and fetch FSM states
package ysyx_23060191_ifu_pkg;
  localparam int CPU_WIDTH = 32;
  localparam logic [CPU_WIDTH-1:0] RESET_PC = 32'h8000_0000;
  localparam logic [CPU_WIDTH-1:0] PC_STEP = 32'd4;
  typedef enum logic [1:0] {IFU_IDLE, IFU_REQ, IFU_HOLD, IFU_FLUSH} ifu_state_e;
endpackage

// File: rtl/ysyx_23060191_ifu_buf.sv
// ysyx_23060191_ifu_buf: one-entry pc/inst holding register with load/clear/valid
module ysyx_23060191_ifu_buf
  import ysyx_23060191_ifu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic                 clear,
  input  logic [CPU_WIDTH-1:0] in_pc,
  input  logic [CPU_WIDTH-1:0] in_inst,
  output logic                 valid,
  output logic [CPU_WIDTH-1:0] pc,
  output logic [CPU_WIDTH-1:0] inst
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      pc <= '0;
      inst <= '0;
    end else if (load) begin
      valid <= 1'b1;
      pc <= in_pc;
      inst <= in_inst;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end
endmodule

// File: rtl/ysyx_23060191_ifu_fetch.sv
// ysyx_23060191_ifu_fetch: PC owner and fetch FSM feeding the IDU through a one-entry buffer
module ysyx_23060191_ifu_fetch
  import ysyx_23060191_ifu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 mem_req,
  output logic [CPU_WIDTH-1:0] mem_addr,
  input  logic [CPU_WIDTH-1:0] mem_rdata,
  input  logic                 mem_rvalid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CPU_WIDTH-1:0] out_pc,
  output logic [CPU_WIDTH-1:0] out_inst,
  input  logic                 redirect_valid,
  input  logic [CPU_WIDTH-1:0] redirect_pc
);
  ifu_state_e state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d, pend_pc, pend_d, pc_inc;
  logic load, clear;
  assign pc_inc = pc_q + PC_STEP;
  assign mem_addr = pc_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IFU_IDLE;
      pc_q <= RESET_PC;
      pend_pc <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      pend_pc <= pend_d;
    end
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    pend_d = pend_pc;
    load = 1'b0;
    clear = 1'b0;
    mem_req = 1'b0;
    case (state_q)
      IFU_IDLE: begin
        state_d = IFU_REQ;
        pc_d = redirect_valid ? redirect_pc : pc_q;
      end
      IFU_REQ: begin
        mem_req = 1'b1;
        if (redirect_valid) begin
          if (mem_rvalid) pc_d = redirect_pc;
          else begin
            pend_d = redirect_pc;
            state_d = IFU_FLUSH;
          end
        end else if (mem_rvalid) begin
          load = 1'b1;
          pc_d = pc_inc;
          state_d = IFU_HOLD;
        end
      end
      IFU_HOLD: begin
        // a redirect here drops the request issued from out_ready
        mem_req = out_ready && !redirect_valid;
        if (redirect_valid) begin
          clear = 1'b1;
          pc_d = redirect_pc;
          state_d = IFU_REQ;
        end else if (out_ready && mem_rvalid) begin
          load = 1'b1;
          pc_d = pc_inc;
        end else if (out_ready) begin
          clear = 1'b1;
          state_d = IFU_REQ;
        end
      end
      IFU_FLUSH: begin
        mem_req = 1'b1;
        if (redirect_valid) pend_d = redirect_pc;
        if (mem_rvalid) begin
          pc_d = redirect_valid ? redirect_pc : pend_pc;
          state_d = IFU_REQ;
        end
      end
      default: state_d = IFU_IDLE;
    endcase
  end
  ysyx_23060191_ifu_buf u_buf (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .clear(clear),
    .in_pc(pc_q),
    .in_inst(mem_rdata),
    .valid(out_valid),
    .pc(out_pc),
    .inst(out_inst)
  );
endmodule

// File: tb/tb_ysyx_23060191_ifu_fetch.sv
// tb_ysyx_23060191_ifu_fetch: directed and randomized checks of the fetch controller
module tb_ysyx_23060191_ifu_fetch;
  localparam logic [31:0] R = 32'h8000_0000;
  logic clk = 1'b0, rst_n = 1'b0;
  logic mem_req, mem_rvalid, out_valid, out_ready = 1'b0, redirect_valid = 1'b0;
  logic [31:0] mem_addr, mem_rdata, out_pc, out_inst, redirect_pc = '0;
  int lat = 0, cnt = 0, checks = 0, errors = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction
  assign mem_rdata = f(mem_addr);
  assign mem_rvalid = mem_req && (cnt >= lat);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= 0;
    else cnt <= (mem_req && !mem_rvalid) ? cnt + 1 : 0;
  ysyx_23060191_ifu_fetch dut (
    .clk(clk), .rst_n(rst_n), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic do_reset(input int l, input logic rdy);
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    out_ready = rdy;
    lat = l;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic wait_valid(input string name, input logic [31:0] exp_pc);
    int n = 0;
    while (!out_valid && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, "_pc"}, out_pc, exp_pc);
    chk({name, "_inst"}, out_inst, f(exp_pc));
  endtask
  task automatic test_reset;
    do_reset(0, 1'b1);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_req", {31'd0, mem_req}, 32'd0);
  endtask
  task automatic test_stream;
    do_reset(0, 1'b1);
    @(negedge clk);
    chk("stream_req", {31'd0, mem_req}, 32'd1);
    chk("stream_addr", mem_addr, R);
    chk("stream_nov", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stream_valid", {31'd0, out_valid}, 32'd1);
      chk("stream_pc", out_pc, R + 32'(4 * i));
      chk("stream_inst", out_inst, f(R + 32'(4 * i)));
    end
  endtask
  task automatic test_stall;
    do_reset(0, 1'b1);
    repeat (3) @(negedge clk);
    out_ready = 1'b0;
    #1 chk("stall_req0", {31'd0, mem_req}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      chk("stall_req", {31'd0, mem_req}, 32'd0);
      chk("stall_pc", out_pc, R + 4);
      chk("stall_inst", out_inst, f(R + 4));
    end
    out_ready = 1'b1;
    #1 chk("stall_rel_req", {31'd0, mem_req}, 32'd1);
    chk("stall_rel_addr", mem_addr, R + 8);
    @(negedge clk);
    chk("stall_next_pc", out_pc, R + 8);
  endtask
  task automatic test_flush;
    do_reset(3, 1'b1);
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = R + 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("flush_stale_req", {31'd0, mem_req}, 32'd1);
    chk("flush_stale_addr", mem_addr, R);
    chk("flush_nov", {31'd0, out_valid}, 32'd0);
    repeat (2) @(negedge clk);
    chk("flush_new_addr", mem_addr, R + 32'h100);
    chk("flush_nov2", {31'd0, out_valid}, 32'd0);
    wait_valid("flush", R + 32'h100);
  endtask
  task automatic test_hold_redirect;
    do_reset(0, 1'b0);
    repeat (2) @(negedge clk);
    chk("hold_valid", {31'd0, out_valid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = R + 32'h200;
    out_ready = 1'b1;
    #1 chk("hold_req_drop", {31'd0, mem_req}, 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("hold_cleared", {31'd0, out_valid}, 32'd0);
    chk("hold_new_addr", mem_addr, R + 32'h200);
    @(negedge clk);
    chk("hold_new_pc", out_pc, R + 32'h200);
  endtask
  task automatic test_double_redirect;
    do_reset(4, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = R + 32'h100;
    @(negedge clk);
    redirect_pc = R + 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("dbl_stale_addr", mem_addr, R);
    wait_valid("dbl", R + 32'h300);
  endtask
  task automatic test_req_redirect;
    do_reset(0, 1'b0);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = R + 32'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("reqrd_nov", {31'd0, out_valid}, 32'd0);
    chk("reqrd_addr", mem_addr, R + 32'h40);
    @(negedge clk);
    chk("reqrd_pc", out_pc, R + 32'h40);
  endtask
  task automatic test_wrap;
    do_reset(0, 1'b1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("wrap_pc0", out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_pc1", out_pc, 32'h0);
  endtask
  task automatic test_reset_in_flush;
    do_reset(0, 1'b0);
    repeat (2) @(negedge clk);
    lat = 5;
    out_ready = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = R + 32'h80;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1 chk("rf_flush_addr", mem_addr, R + 4);
    chk("rf_held_pc", out_pc, R);
    #2 rst_n = 1'b0;
    #1 chk("rf_req", {31'd0, mem_req}, 32'd0);
    chk("rf_pc", out_pc, 32'd0);
    chk("rf_inst", out_inst, 32'd0);
    chk("rf_valid", {31'd0, out_valid}, 32'd0);
    lat = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rf_restart_addr", mem_addr, R);
    @(negedge clk);
    chk("rf_restart_pc", out_pc, R);
  endtask
  task automatic test_random;
    logic [31:0] exp_pc, prev_addr;
    logic prev_pending;
    int hs;
    for (int p = 0; p < 4; p++) begin
      do_reset(p, 1'b0);
      exp_pc = R;
      prev_pending = 1'b0;
      prev_addr = '0;
      hs = 0;
      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        out_ready = ($urandom_range(0, 9) < 7);
        redirect_valid = ($urandom_range(0, 19) == 0);
        redirect_pc = R + {20'd0, 10'($urandom), 2'b00};
        #1;
        if (prev_pending) begin
          chk("rnd_req_stable", {31'd0, mem_req}, 32'd1);
          chk("rnd_addr_stable", mem_addr, prev_addr);
        end
        if (out_valid && out_ready) begin
          hs++;
          chk("rnd_pc", out_pc, exp_pc);
          chk("rnd_inst", out_inst, f(exp_pc));
          exp_pc = exp_pc + 4;
        end
        if (redirect_valid) exp_pc = redirect_pc;
        prev_pending = mem_req && !mem_rvalid && !redirect_valid;
        prev_addr = mem_addr;
      end
      redirect_valid = 1'b0;
      chk("rnd_progress", {31'd0, hs > 50}, 32'd1);
    end
  endtask
  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_flush;
    test_hold_redirect;
    test_double_redirect;
    test_req_redirect;
    test_wrap;
    test_reset_in_flush;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/ysyx_23060191_ifu_fetch.md
Name: ysyx_23060191_ifu_fetch

Overview:
Fetch controller directly upstream of the instruction-memory read stage. It owns the PC register, drives the memory read request (pc/rd_en side), and captures the returned instruction into a one-entry buffer. It hands the instruction to the IDU over a valid/ready handshake and accepts PC redirects from EXU, squashing stale fetches.

Parameters:
CPU_WIDTH, 32, data/address width (from shared defines)
RESET_PC, 32'h8000_0000, first fetch address after reset
PC_STEP, 4, sequential PC increment

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
mem_req  out  1  read request to instruction memory (rd_en)
mem_addr  out  CPU_WIDTH  fetch address to memory (pc)
mem_rdata  in  CPU_WIDTH  instruction returned by memory
mem_rvalid  in  1  mem_rdata valid for the current request; combinational memory ties this to mem_req
out_valid  out  1  buffered instruction valid toward IDU
out_ready  in  1  IDU accepts this cycle
out_pc  out  CPU_WIDTH  PC of buffered instruction
out_inst  out  CPU_WIDTH  buffered instruction
redirect_valid  in  1  EXU redirect (branch/jump/trap), single-cycle pulse
redirect_pc  in  CPU_WIDTH  redirect target

Behaviour:
- Reset (async, rst_n=0): pc_q=RESET_PC, pend_pc=0, state=IDLE, out_valid=0, out_pc=0, out_inst=0. mem_req=0 combinationally in IDLE. Deassertion is sampled synchronously.
- States: IDLE, REQ, HOLD, FLUSH.
  - IDLE: mem_req=0. Next cycle goes to REQ.
  - REQ: mem_req=1, mem_addr=pc_q.
    - On mem_rvalid: out_inst<=mem_rdata, out_pc<=pc_q, out_valid<=1, pc_q<=pc_q+PC_STEP; go to HOLD.
  - HOLD: out_valid=1 and outputs stay stable until the handshake.
    - out_ready=1: mem_req=1 and mem_addr=pc_q in the same cycle (combinational path from out_ready).
      - With mem_rvalid: reload the buffer as in REQ and stay in HOLD. This gives 1 instr/cycle with combinational memory.
      - Without mem_rvalid: out_valid<=0; go to REQ.
    - out_ready=0: mem_req=0.
  - FLUSH: mem_req=1, mem_addr=pc_q (the outstanding stale address).
    - On mem_rvalid: discard the data, pc_q<=pend_pc, go to REQ.
- Memory contract: once mem_req rises, it and mem_addr stay stable until mem_rvalid. Exception: a redirect in the same cycle may drop a HOLD-issued request. One response per request.
- Redirect has priority over all other events:
  - IDLE: pc_q<=redirect_pc; go to REQ.
  - REQ with mem_rvalid=1: discard data, pc_q<=redirect_pc, stay in REQ. A new request is issued next cycle.
  - REQ with mem_rvalid=0: pend_pc<=redirect_pc; go to FLUSH.
  - HOLD: mem_req forced 0, out_valid<=0, pc_q<=redirect_pc; go to REQ. A handshake completing that same cycle counts as accepted by IDU; squashing it is downstream's job.
  - FLUSH: pend_pc<=redirect_pc (latest wins). If mem_rvalid is also high, pc_q<=redirect_pc; go to REQ.
- PC arithmetic is modulo 2^CPU_WIDTH; 32'hFFFF_FFFC+4 wraps to 0. No alignment check.
- Latency: with combinational memory, the instruction is visible on out_inst 1 cycle after mem_req. The first fetch reaches out_valid 2 cycles after reset release (IDLE, REQ, HOLD).
- Reset mid-operation: all state is cleared immediately and any in-flight response is ignored.

Decomposition:
- Shared defines file: CPU_WIDTH, RESET_PC, PC_STEP, state encodings (IFU_IDLE/REQ/HOLD/FLUSH).
- One natural sub-module: ysyx_23060191_ifu_buf, a one-entry pc/inst holding register with load/clear/valid. FSM and PC stay in the top.

Test Plan:
- Reset, combinational memory (rvalid=mem_req), out_ready=1 -> mem_addr 0x80000000 in cycle 1. out_pc 0x80000000, 0x80000004, 0x80000008 on consecutive cycles, one instr/cycle.
- out_ready=0 for 5 cycles while out_valid=1 -> mem_req=0, and out_pc/out_inst hold 0x80000004/stable data. On release the next fetch is 0x80000008.
- 3-cycle memory latency, redirect_pc=0x80000100 one cycle after the request -> FLUSH. The stale response is dropped and the next mem_addr is 0x80000100. out_valid never shows the stale instruction.
- Redirect to 0x80000200 while in HOLD with out_valid=1 -> out_valid=0 next cycle, no mem_req that cycle. The next request goes to 0x80000200.
- Two redirects in FLUSH (0x100 then 0x300) -> the fetch resumes at 0x300. A redirect coincident with mem_rvalid in REQ -> data discarded, next mem_addr = target.
- Assert rst_n=0 while in FLUSH -> outputs 0 and state IDLE asynchronously. After release, fetch restarts at 0x80000000.
